// File: rtl/audio_pkg.sv
// Shared audio definitions: sound identifiers, sample ROM layout and sequencer states.
package audio_pkg;

    typedef enum logic {SND_TIC, SND_EXPL} sound_id_t;

    typedef enum logic [1:0] {IDLE, FIRE, PLAY} seq_state_t;

    // Sample ROM layout as seen by the player
    localparam int unsigned TIC_ROM_START  = 0;
    localparam int unsigned TIC_ROM_END    = 3846;
    localparam int unsigned EXPL_ROM_START = 3847;
    localparam int unsigned EXPL_ROM_END   = 11964;

    // One sample is consumed per LR frame
    localparam int unsigned TIC_ROM_FRAMES   = TIC_ROM_END - TIC_ROM_START + 1;
    localparam int unsigned EXPL_ROM_FRAMES  = EXPL_ROM_END - EXPL_ROM_START + 1;
    localparam int unsigned SEQ_GUARD_FRAMES = 2;

endpackage

// File: rtl/audio_lr_sync.sv
// Brings the codec LR clock into the clk domain and flags its falling edges.
module audio_lr_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic audio_lr,
    output logic lr_fall
);

    logic lr_meta;
    logic lr_sync;
    logic lr_hist;

    // Two-flop synchroniser followed by a history flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lr_meta <= 1'b0;
            lr_sync <= 1'b0;
            lr_hist <= 1'b0;
        end else begin
            lr_meta <= audio_lr;
            lr_sync <= lr_meta;
            lr_hist <= lr_sync;
        end
    end

    assign lr_fall = lr_hist & ~lr_sync;

endmodule

// File: rtl/sound_sequencer.sv
// Queues game sound events and issues one trigger at a time to the sample player,
// timing playback by counting LR frames since the player has no busy output.
module sound_sequencer #(
    parameter int unsigned TICTAC_FRAMES    = audio_pkg::TIC_ROM_FRAMES,
    parameter int unsigned EXPLOSION_FRAMES = audio_pkg::EXPL_ROM_FRAMES,
    parameter int unsigned GUARD_FRAMES     = audio_pkg::SEQ_GUARD_FRAMES,
    parameter int unsigned PEND_W           = 2,
    parameter int unsigned FRM_W            = 14
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              audio_lr,
    input  logic              ev_tictac,
    input  logic              ev_explosion,
    input  logic              mute,
    output logic              tictac,
    output logic              explosion,
    output logic              busy,
    output logic              drop,
    output logic [PEND_W-1:0] pend_tictac,
    output logic [PEND_W-1:0] pend_explosion
);

    import audio_pkg::*;

    localparam logic [FRM_W-1:0] TIC_LOAD  = FRM_W'(TICTAC_FRAMES + GUARD_FRAMES);
    localparam logic [FRM_W-1:0] EXPL_LOAD = FRM_W'(EXPLOSION_FRAMES + GUARD_FRAMES);

    seq_state_t        state_q;
    seq_state_t        state_d;
    sound_id_t         sel_q;
    sound_id_t         sel_d;
    logic [FRM_W-1:0]  frm_q;
    logic [FRM_W-1:0]  frm_d;
    logic              disp_tic;
    logic              disp_expl;
    logic [PEND_W-1:0] pend_tic_d;
    logic [PEND_W-1:0] pend_expl_d;
    logic              sat_tic;
    logic              sat_expl;
    logic              lr_fall;

    audio_lr_sync u_lr_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .audio_lr (audio_lr),
        .lr_fall  (lr_fall)
    );

    // Next state: dispatch from IDLE (explosion first), one FIRE cycle, then count frames
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        frm_d     = frm_q;
        disp_tic  = 1'b0;
        disp_expl = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!mute) begin
                    if (pend_explosion != '0) begin
                        state_d   = FIRE;
                        sel_d     = SND_EXPL;
                        frm_d     = EXPL_LOAD;
                        disp_expl = 1'b1;
                    end else if (pend_tictac != '0) begin
                        state_d  = FIRE;
                        sel_d    = SND_TIC;
                        frm_d    = TIC_LOAD;
                        disp_tic = 1'b1;
                    end
                end
            end
            FIRE: begin
                state_d = PLAY;
            end
            PLAY: begin
                if (lr_fall) begin
                    frm_d = frm_q - FRM_W'(1);
                    if (frm_q == FRM_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pending counts: mute flushes, simultaneous event and dispatch cancel, saturation drops
    always_comb begin
        pend_tic_d  = pend_tictac;
        pend_expl_d = pend_explosion;
        sat_tic     = 1'b0;
        sat_expl    = 1'b0;
        if (mute) begin
            pend_tic_d  = '0;
            pend_expl_d = '0;
        end else begin
            if (ev_tictac && !disp_tic) begin
                if (pend_tictac == '1) begin
                    sat_tic = 1'b1;
                end else begin
                    pend_tic_d = pend_tictac + PEND_W'(1);
                end
            end else if (disp_tic && !ev_tictac) begin
                pend_tic_d = pend_tictac - PEND_W'(1);
            end
            if (ev_explosion && !disp_expl) begin
                if (pend_explosion == '1) begin
                    sat_expl = 1'b1;
                end else begin
                    pend_expl_d = pend_explosion + PEND_W'(1);
                end
            end else if (disp_expl && !ev_explosion) begin
                pend_expl_d = pend_explosion - PEND_W'(1);
            end
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            sel_q          <= SND_TIC;
            frm_q          <= '0;
            pend_tictac    <= '0;
            pend_explosion <= '0;
            drop           <= 1'b0;
            tictac         <= 1'b0;
            explosion      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            frm_q          <= frm_d;
            pend_tictac    <= pend_tic_d;
            pend_explosion <= pend_expl_d;
            drop           <= sat_tic | sat_expl;
            tictac         <= (state_d == FIRE) && (sel_d == SND_TIC);
            explosion      <= (state_d == FIRE) && (sel_d == SND_EXPL);
            busy           <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer with short sample lengths.
module tb_sound_sequencer;

    localparam int unsigned TIC_N   = 5;
    localparam int unsigned EXPL_N  = 9;
    localparam int unsigned GUARD_N = 2;
    localparam int unsigned PW      = 2;
    localparam int unsigned FW      = 14;
    localparam int TIC_PLAY  = TIC_N + GUARD_N;
    localparam int EXPL_PLAY = EXPL_N + GUARD_N;
    localparam int PEND_MAX  = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          audio_lr = 1'b1;
    logic          ev_tictac = 1'b0;
    logic          ev_explosion = 1'b0;
    logic          mute = 1'b0;
    logic          tictac;
    logic          explosion;
    logic          busy;
    logic          drop;
    logic [PW-1:0] pend_tictac;
    logic [PW-1:0] pend_explosion;

    int checks = 0;
    int errors = 0;
    int falls  = 0;
    int n_tic  = 0;
    int n_expl = 0;
    logic prev_tic  = 1'b0;
    logic prev_expl = 1'b0;

    sound_sequencer #(
        .TICTAC_FRAMES    (TIC_N),
        .EXPLOSION_FRAMES (EXPL_N),
        .GUARD_FRAMES     (GUARD_N),
        .PEND_W           (PW),
        .FRM_W            (FW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .audio_lr       (audio_lr),
        .ev_tictac      (ev_tictac),
        .ev_explosion   (ev_explosion),
        .mute           (mute),
        .tictac         (tictac),
        .explosion      (explosion),
        .busy           (busy),
        .drop           (drop),
        .pend_tictac    (pend_tictac),
        .pend_explosion (pend_explosion)
    );

    initial forever #5 clk = ~clk;

    // LR clock: 64 clk period, edges kept clear of the clk rising edge
    initial begin
        #2;
        forever #320 audio_lr = ~audio_lr;
    end

    always @(negedge audio_lr) falls++;

    // Trigger rules hold on every cycle: never both, never wider than one cycle
    always @(posedge clk) begin
        #1;
        checks++;
        if (tictac === 1'b1 && explosion === 1'b1) begin
            errors++;
            $display("FAIL trig_exclusive: tictac=%b explosion=%b, required not both high", tictac, explosion);
        end
        checks++;
        if ((tictac === 1'b1 && prev_tic) || (explosion === 1'b1 && prev_expl)) begin
            errors++;
            $display("FAIL trig_width: tictac=%b explosion=%b high for 2 cycles, required 1", tictac, explosion);
        end
        if (tictac === 1'b1) n_tic++;
        if (explosion === 1'b1) n_expl++;
        prev_tic  = (tictac === 1'b1);
        prev_expl = (explosion === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns on the first clk edge after the next LR pin fall
    task automatic wait_fall();
        int f0 = falls;
        int n  = 0;
        while (falls == f0 && n < 100) begin
            tick();
            n++;
        end
        if (falls == f0) begin
            checks++;
            errors++;
            $display("FAIL lr_fall_timeout: no LR fall within %0d cycles", n);
        end
    endtask

    task automatic wait_phase();
        wait_fall();
        repeat ($urandom_range(8, 30)) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({tictac, explosion, busy, drop, pend_tictac, pend_explosion} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: t=%b e=%b b=%b d=%b pt=%0d pe=%0d, required all 0",
                     tictac, explosion, busy, drop, pend_tictac, pend_explosion);
        end
        reset_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || pend_tictac !== '0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b pend_tictac=%0d, required 0 0", busy, pend_tictac);
        end
    endtask

    task automatic test_single_tictac();
        int t0 = n_tic;
        int e0 = n_expl;
        wait_phase();
        ev_tictac = 1'b1; tick(); ev_tictac = 1'b0;
        checks++;
        if (pend_tictac !== PW'(1) || tictac !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_queued: pend=%0d tictac=%b busy=%b, required 1 0 0", pend_tictac, tictac, busy);
        end
        tick();
        checks++;
        if (tictac !== 1'b1 || busy !== 1'b1 || pend_tictac !== '0) begin
            errors++;
            $display("FAIL single_trigger: tictac=%b busy=%b pend=%0d, required 1 1 0", tictac, busy, pend_tictac);
        end
        tick();
        checks++;
        if (tictac !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_after_fire: tictac=%b busy=%b, required 0 1", tictac, busy);
        end
        for (int k = 1; k <= TIC_PLAY; k++) begin
            wait_fall();
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL single_busy_hold: fall %0d busy=%b, required 1", k, busy);
            end
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_late: busy=%b, required 1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_end: busy=%b, required 0", busy);
        end
        checks++;
        if (n_tic - t0 != 1 || n_expl != e0) begin
            errors++;
            $display("FAIL single_pulse_count: tic=%0d expl=%0d, required 1 0", n_tic - t0, n_expl - e0);
        end
    endtask

    task automatic test_priority();
        int t0 = n_tic;
        int e0 = n_expl;
        wait_phase();
        ev_tictac = 1'b1; ev_explosion = 1'b1; tick();
        ev_tictac = 1'b0; ev_explosion = 1'b0;
        tick();
        checks++;
        if (explosion !== 1'b1 || tictac !== 1'b0 || pend_tictac !== PW'(1) || pend_explosion !== '0) begin
            errors++;
            $display("FAIL prio_first: expl=%b tic=%b pt=%0d pe=%0d, required 1 0 1 0",
                     explosion, tictac, pend_tictac, pend_explosion);
        end
        for (int k = 1; k <= EXPL_PLAY; k++) begin
            wait_fall();
            checks++;
            if (busy !== 1'b1 || tictac !== 1'b0) begin
                errors++;
                $display("FAIL prio_expl_hold: fall %0d busy=%b tictac=%b, required 1 0", k, busy, tictac);
            end
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL prio_expl_end: busy=%b, required 0", busy);
        end
        tick();
        checks++;
        if (tictac !== 1'b1 || busy !== 1'b1 || pend_tictac !== '0) begin
            errors++;
            $display("FAIL prio_second: tictac=%b busy=%b pt=%0d, required 1 1 0", tictac, busy, pend_tictac);
        end
        for (int k = 1; k <= TIC_PLAY; k++) wait_fall();
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL prio_tic_end: busy=%b, required 0", busy);
        end
        checks++;
        if (n_tic - t0 != 1 || n_expl - e0 != 1) begin
            errors++;
            $display("FAIL prio_pulse_count: tic=%0d expl=%0d, required 1 1", n_tic - t0, n_expl - e0);
        end
    endtask

    task automatic test_saturation();
        int m_tic = 0;
        int m_expl = 0;
        int f0;
        int n;
        int t0;
        int e0;
        bit exp_drop;
        int unsigned pick;
        wait_phase();
        ev_explosion = 1'b1; tick(); ev_explosion = 1'b0;
        tick();
        f0 = falls;
        checks++;
        if (explosion !== 1'b1) begin
            errors++;
            $display("FAIL sat_trigger: explosion=%b, required 1", explosion);
        end
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(1, 15)) tick();
            ev_tictac = 1'b1; tick(); ev_tictac = 1'b0;
            exp_drop = (m_tic == PEND_MAX);
            if (!exp_drop) m_tic++;
            checks++;
            if (pend_tictac !== PW'(m_tic) || drop !== exp_drop) begin
                errors++;
                $display("FAIL sat_tic_event%0d: pend=%0d drop=%b, required %0d %b", i, pend_tictac, drop, m_tic, exp_drop);
            end
        end
        for (int i = 0; i < 6; i++) begin
            pick = $urandom_range(1, 3);
            tick();
            checks++;
            if (drop !== 1'b0) begin
                errors++;
                $display("FAIL sat_drop_clear: drop=%b, required 0", drop);
            end
            repeat ($urandom_range(0, 10)) tick();
            ev_tictac = pick[0]; ev_explosion = pick[1]; tick();
            ev_tictac = 1'b0; ev_explosion = 1'b0;
            exp_drop = 1'b0;
            if (pick[0]) begin
                if (m_tic == PEND_MAX) exp_drop = 1'b1;
                else m_tic++;
            end
            if (pick[1]) begin
                if (m_expl == PEND_MAX) exp_drop = 1'b1;
                else m_expl++;
            end
            checks++;
            if (pend_tictac !== PW'(m_tic) || pend_explosion !== PW'(m_expl) || drop !== exp_drop) begin
                errors++;
                $display("FAIL sat_mixed%0d: pt=%0d pe=%0d drop=%b, required %0d %0d %b",
                         i, pend_tictac, pend_explosion, drop, m_tic, m_expl, exp_drop);
            end
        end
        mute = 1'b1; tick(); mute = 1'b0;
        checks++;
        if (pend_tictac !== '0 || pend_explosion !== '0 || drop !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL sat_flush: pt=%0d pe=%0d drop=%b busy=%b, required 0 0 0 1",
                     pend_tictac, pend_explosion, drop, busy);
        end
        n = 0;
        while (falls < f0 + EXPL_PLAY && n < 1000) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL sat_busy_late: busy=%b, required 1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL sat_busy_end: busy=%b, required 0", busy);
        end
        t0 = n_tic;
        e0 = n_expl;
        repeat (150) tick();
        checks++;
        if (n_tic != t0 || n_expl != e0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sat_no_retrigger: tic=%0d expl=%0d busy=%b, required 0 0 0", n_tic - t0, n_expl - e0, busy);
        end
    endtask

    task automatic test_mute();
        int f0;
        int n;
        int t0;
        int e0;
        wait_phase();
        ev_tictac = 1'b1; tick(); ev_tictac = 1'b0;
        tick();
        f0 = falls;
        checks++;
        if (tictac !== 1'b1) begin
            errors++;
            $display("FAIL mute_trigger: tictac=%b, required 1", tictac);
        end
        for (int i = 0; i < 2; i++) begin
            repeat ($urandom_range(1, 5)) tick();
            ev_tictac = 1'b1; tick(); ev_tictac = 1'b0;
        end
        checks++;
        if (pend_tictac !== PW'(2)) begin
            errors++;
            $display("FAIL mute_pending: pend=%0d, required 2", pend_tictac);
        end
        mute = 1'b1; ev_tictac = 1'b1; tick();
        mute = 1'b0; ev_tictac = 1'b0;
        checks++;
        if (pend_tictac !== '0 || drop !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mute_flush: pend=%0d drop=%b busy=%b, required 0 0 1", pend_tictac, drop, busy);
        end
        n = 0;
        while (falls < f0 + TIC_PLAY && n < 1000) begin
            tick();
            n++;
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mute_play_end: busy=%b, required 0", busy);
        end
        t0 = n_tic;
        e0 = n_expl;
        repeat (150) tick();
        checks++;
        if (n_tic != t0 || n_expl != e0) begin
            errors++;
            $display("FAIL mute_no_trigger: tic=%0d expl=%0d, required 0 0", n_tic - t0, n_expl - e0);
        end
    endtask

    task automatic test_back_to_back();
        wait_phase();
        ev_explosion = 1'b1; tick();
        tick();
        ev_explosion = 1'b0;
        checks++;
        if (explosion !== 1'b1 || pend_explosion !== PW'(1)) begin
            errors++;
            $display("FAIL b2b_same_edge: expl=%b pend=%0d, required 1 1", explosion, pend_explosion);
        end
        for (int k = 1; k <= EXPL_PLAY; k++) wait_fall();
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_end: busy=%b, required 0", busy);
        end
        tick();
        checks++;
        if (explosion !== 1'b1 || pend_explosion !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: expl=%b pend=%0d busy=%b, required 1 0 1", explosion, pend_explosion, busy);
        end
        for (int k = 1; k <= EXPL_PLAY; k++) wait_fall();
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_end: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_play();
        wait_phase();
        ev_explosion = 1'b1; tick(); ev_explosion = 1'b0;
        tick();
        repeat (3) wait_fall();
        ev_tictac = 1'b1; tick(); ev_tictac = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, tictac, explosion, drop, pend_tictac, pend_explosion} !== '0) begin
            errors++;
            $display("FAIL rst_async: busy=%b t=%b e=%b d=%b pt=%0d pe=%0d, required all 0",
                     busy, tictac, explosion, drop, pend_tictac, pend_explosion);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        wait_phase();
        ev_explosion = 1'b1; tick(); ev_explosion = 1'b0;
        checks++;
        if (explosion !== 1'b0) begin
            errors++;
            $display("FAIL rst_early_trigger: explosion=%b, required 0", explosion);
        end
        tick();
        checks++;
        if (explosion !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_restart: explosion=%b busy=%b, required 1 1", explosion, busy);
        end
        for (int k = 1; k <= EXPL_PLAY; k++) wait_fall();
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_restart_end: busy=%b, required 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_tictac();
        test_priority();
        test_saturation();
        test_mute();
        test_back_to_back();
        test_reset_mid_play();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
